// File: rtl/ps2_pkg.sv
// Shared constants, types and key classification for the PS/2 key tracker.
// Scan-code prefixes, key_state encodings and decoder states live here.
package ps2_pkg;

  typedef enum logic [1:0] {
    KS_NOKEY = 2'b00,
    KS_UP    = 2'b01,
    KS_DOWN  = 2'b10,
    KS_OTHER = 2'b11
  } key_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_SKIP
  } dec_state_e;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;
  localparam logic [7:0] FAKE_SHIFT = 8'h12;
  localparam logic [7:0] RSP_AA = 8'hAA;
  localparam logic [7:0] RSP_FA = 8'hFA;
  localparam logic [7:0] RSP_FE = 8'hFE;

  localparam logic [2:0] E1_SKIP_BYTES = 3'd7;

  localparam int NUM_UP   = 4;
  localparam int NUM_DOWN = 3;

  localparam logic [8:0] UP_CODES [NUM_UP] =
    '{9'h01D, 9'h043, 9'h029, 9'h175};
  localparam logic [8:0] DOWN_CODES [NUM_DOWN] =
    '{9'h01B, 9'h042, 9'h172};

  typedef struct packed {
    logic [8:0] code;
    logic       brk;
    logic       rep;
  } key_evt_t;

  function automatic key_state_e key_class(
    input logic [8:0] code
  );
    key_state_e cls;
    cls = KS_OTHER;
    for (int i = 0; i < NUM_UP; i++)
      if (code == UP_CODES[i]) cls = KS_UP;
    for (int i = 0; i < NUM_DOWN; i++)
      if (code == DOWN_CODES[i]) cls = KS_DOWN;
    return cls;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronisers, falling-edge sampling,
// parity/stop check and stalled-frame timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic [3:0]    bitcnt_q;
  logic [8:0]    shreg_q;
  logic [TW-1:0] tmo_q;
  logic          byte_vld_q;
  logic [7:0]    byte_q;
  logic          err_q;

  logic fall;
  logic din;

  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign din  = dat_sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      tmo_q      <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      byte_vld_q <= 1'b0;
      err_q      <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        unique case (1'b1)
          (bitcnt_q == 4'd0): begin
            // a high start bit is line noise, not a frame
            if (!din) bitcnt_q <= 4'd1;
          end
          (bitcnt_q == 4'd10): begin
            bitcnt_q <= '0;
            if ((^shreg_q) && din) begin
              byte_vld_q <= 1'b1;
              byte_q     <= shreg_q[7:0];
            end else begin
              err_q <= 1'b1;
            end
          end
          default: begin
            shreg_q  <= {din, shreg_q[8:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
          end
        endcase
      end else if (bitcnt_q != 4'd0) begin
        if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          bitcnt_q <= '0;
          tmo_q    <= '0;
          err_q    <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign byte_vld_o  = byte_vld_q;
  assign byte_o      = byte_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard scan-code decoder with a held-key table and
// a single-entry event register with valid/ready handshake.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [8:0]                 evt_code,
  output logic                       evt_break,
  output logic                       evt_repeat,
  output logic [$clog2(DEPTH+1)-1:0] held_cnt,
  output logic [1:0]                 key_state,
  output logic                       frame_err,
  output logic                       evt_drop
);

  localparam int CW = $clog2(DEPTH + 1);

  logic       byte_vld;
  logic [7:0] rx_byte;

  ps2_rx_frame #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .byte_vld_o (byte_vld),
    .byte_o     (rx_byte),
    .frame_err_o(frame_err)
  );

  dec_state_e st_q, st_d;
  logic [2:0] skip_q, skip_d;

  logic       go;
  logic       go_brk;
  logic [8:0] go_code;

  always_comb begin
    st_d    = st_q;
    skip_d  = skip_q;
    go      = 1'b0;
    go_brk  = 1'b0;
    go_code = 9'h000;
    if (byte_vld) begin
      unique case (st_q)
        ST_IDLE: begin
          unique case (1'b1)
            (rx_byte == PFX_E0): st_d = ST_E0;
            (rx_byte == PFX_F0): st_d = ST_F0;
            (rx_byte == PFX_E1): begin
              st_d   = ST_SKIP;
              skip_d = E1_SKIP_BYTES;
            end
            (rx_byte == RSP_AA ||
             rx_byte == RSP_FA ||
             rx_byte == RSP_FE): st_d = ST_IDLE;
            default: begin
              go      = 1'b1;
              go_code = {1'b0, rx_byte};
            end
          endcase
        end
        ST_E0: begin
          unique case (1'b1)
            (rx_byte == PFX_F0):     st_d = ST_E0F0;
            (rx_byte == FAKE_SHIFT): st_d = ST_E0;
            default: begin
              go      = 1'b1;
              go_code = {1'b1, rx_byte};
              st_d    = ST_IDLE;
            end
          endcase
        end
        ST_F0: begin
          go      = 1'b1;
          go_brk  = 1'b1;
          go_code = {1'b0, rx_byte};
          st_d    = ST_IDLE;
        end
        ST_E0F0: begin
          st_d = ST_IDLE;
          if (rx_byte != FAKE_SHIFT) begin
            go      = 1'b1;
            go_brk  = 1'b1;
            go_code = {1'b1, rx_byte};
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) st_d = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  logic [8:0]  tbl_q [DEPTH];
  logic [8:0]  tbl_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit;
  logic [CW-1:0] hit_idx;
  logic          rep;
  key_state_e    ks_q, ks_d;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && CW'(i) < cnt_q &&
          tbl_q[i] == go_code) begin
        hit     = 1'b1;
        hit_idx = CW'(i);
      end
    end
  end

  always_comb begin
    tbl_d = tbl_q;
    cnt_d = cnt_q;
    rep   = 1'b0;
    if (go && !go_brk) begin
      if (hit) begin
        rep = 1'b1;
      end else if (cnt_q < CW'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == cnt_q) tbl_d[i] = go_code;
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (go && go_brk && hit) begin
      // close the gap so entry cnt-1 stays the newest press
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) >= hit_idx) begin
          if (i == DEPTH - 1) tbl_d[i] = '0;
          else tbl_d[i] = tbl_q[(i + 1) % DEPTH];
        end
      end
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    ks_d = KS_NOKEY;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i + 1) == cnt_d) ks_d = key_class(tbl_d[i]);
  end

  key_evt_t evt_q;
  logic     evt_valid_q;
  logic     drop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      skip_q      <= '0;
      cnt_q       <= '0;
      ks_q        <= KS_NOKEY;
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else begin
      st_q   <= st_d;
      skip_q <= skip_d;
      cnt_q  <= cnt_d;
      ks_q   <= ks_d;
      tbl_q  <= tbl_d;
      drop_q <= 1'b0;
      if (go) begin
        if (evt_valid_q && !evt_ready) begin
          drop_q <= 1'b1;
        end else begin
          evt_valid_q <= 1'b1;
          evt_q       <= '{code: go_code, brk: go_brk, rep: rep};
        end
      end else if (evt_ready) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_code   = evt_q.code;
  assign evt_break  = evt_q.brk;
  assign evt_repeat = evt_q.rep;
  assign held_cnt   = cnt_q;
  assign key_state  = ks_q;
  assign evt_drop   = drop_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: vector table of key
// sequences plus hand-written error, backpressure and reset cases.
module tb_ps2_key_tracker;

  localparam int DEPTH = 4;
  localparam int TMO   = 200;
  localparam int H     = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [8:0] evt_code;
  logic       evt_break;
  logic       evt_repeat;
  logic [2:0] held_cnt;
  logic [1:0] key_state;
  logic       frame_err;
  logic       evt_drop;

  ps2_key_tracker #(
    .DEPTH(DEPTH),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_repeat(evt_repeat),
    .held_cnt  (held_cnt),
    .key_state (key_state),
    .frame_err (frame_err),
    .evt_drop  (evt_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] code;
    logic       brk;
    logic       rep;
  } exp_t;

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    bit         ev;
    logic [8:0] code;
    bit         brk;
    bit         rep;
    logic [2:0] hc;
    logic [1:0] ks;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   err_seen = 0;
  int   drop_seen = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(
    int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
    bit ev, logic [8:0] code, bit brk, bit rep,
    logic [2:0] hc, logic [1:0] ks);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.ev = ev; v.code = code; v.brk = brk; v.rep = rep;
    v.hc = hc; v.ks = ks;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (evt_drop) drop_seen++;
      if (evt_valid && evt_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h brk=%0b",
                   evt_code, evt_break);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("evt_code", int'(evt_code), int'(e.code));
          chk("evt_break", int'(evt_break), int'(e.brk));
          chk("evt_repeat", int'(evt_repeat), int'(e.rep));
        end
      end
    end
  end

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(logic [7:0] b, bit bad, int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      ps2_data = f[k];
      wait_clk(H);
      ps2_clk = 1'b0;
      wait_clk(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(2 * H);
  endtask

  task automatic push(logic [8:0] c, logic b, logic r);
    exp_t e;
    e.code = c; e.brk = b; e.rep = r;
    sb.push_back(e);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[19];

  initial begin
    logic [7:0] e1seq [8];
    int e0;
    int d0;

    vt[0]  = mk(1, 8'h1D, 0, 0, 1, 9'h01D, 0, 0, 1, 2'b01);
    vt[1]  = mk(2, 8'hF0, 8'h1D, 0, 1, 9'h01D, 1, 0, 0, 2'b00);
    vt[2]  = mk(2, 8'hE0, 8'h72, 0, 1, 9'h172, 0, 0, 1, 2'b10);
    vt[3]  = mk(3, 8'hE0, 8'hF0, 8'h72, 1, 9'h172, 1, 0, 0, 2'b00);
    vt[4]  = mk(1, 8'h1D, 0, 0, 1, 9'h01D, 0, 0, 1, 2'b01);
    vt[5]  = mk(1, 8'h1B, 0, 0, 1, 9'h01B, 0, 0, 2, 2'b10);
    vt[6]  = mk(1, 8'h1C, 0, 0, 1, 9'h01C, 0, 0, 3, 2'b11);
    vt[7]  = mk(1, 8'h2A, 0, 0, 1, 9'h02A, 0, 0, 4, 2'b11);
    vt[8]  = mk(1, 8'h33, 0, 0, 1, 9'h033, 0, 0, 4, 2'b11);
    vt[9]  = mk(1, 8'h1D, 0, 0, 1, 9'h01D, 0, 1, 4, 2'b11);
    vt[10] = mk(2, 8'hF0, 8'h1B, 0, 1, 9'h01B, 1, 0, 3, 2'b11);
    vt[11] = mk(2, 8'hF0, 8'h2A, 0, 1, 9'h02A, 1, 0, 2, 2'b11);
    vt[12] = mk(2, 8'hF0, 8'h1C, 0, 1, 9'h01C, 1, 0, 1, 2'b01);
    vt[13] = mk(2, 8'hF0, 8'h33, 0, 1, 9'h033, 1, 0, 1, 2'b01);
    vt[14] = mk(3, 8'hE0, 8'h12, 8'h75, 1, 9'h175, 0, 0, 2, 2'b01);
    vt[15] = mk(3, 8'hE0, 8'hF0, 8'h12, 0, 9'h000, 0, 0, 2, 2'b01);
    vt[16] = mk(3, 8'hE0, 8'hF0, 8'h75, 1, 9'h175, 1, 0, 1, 2'b01);
    vt[17] = mk(2, 8'hF0, 8'h1D, 0, 1, 9'h01D, 1, 0, 0, 2'b00);
    vt[18] = mk(1, 8'hFA, 0, 0, 0, 9'h000, 0, 0, 0, 2'b00);

    rst_n     = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    evt_ready = 1'b1;
    wait_clk(4);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_held", int'(held_cnt), 0);
    chk("rst_state", int'(key_state), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_drop", int'(evt_drop), 0);
    rst_n = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 19; i++) begin
      if (vt[i].ev) push(vt[i].code, vt[i].brk, vt[i].rep);
      send_frame(vt[i].b0, 0, 11);
      if (vt[i].n > 1) send_frame(vt[i].b1, 0, 11);
      if (vt[i].n > 2) send_frame(vt[i].b2, 0, 11);
      wait_clk(4);
      chk($sformatf("held_cnt[%0d]", i), int'(held_cnt), int'(vt[i].hc));
      chk($sformatf("key_state[%0d]", i), int'(key_state), int'(vt[i].ks));
      chk($sformatf("sb_empty[%0d]", i), sb.size(), 0);
    end

    // bad parity, then a frame stalled after 5 bits
    e0 = err_seen;
    send_frame(8'h1D, 1, 11);
    send_frame(8'h1B, 0, 5);
    wait_clk(TMO + 50);
    chk("frame_err_pulses", err_seen - e0, 2);
    chk("err_held", int'(held_cnt), 0);

    // pause sequence is swallowed whole
    e1seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int k = 0; k < 8; k++) send_frame(e1seq[k], 0, 11);
    wait_clk(4);
    chk("e1_held", int'(held_cnt), 0);
    push(9'h029, 0, 0);
    send_frame(8'h29, 0, 11);
    wait_clk(4);
    chk("e1_after_held", int'(held_cnt), 1);
    chk("e1_after_state", int'(key_state), 1);
    push(9'h029, 1, 0);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h29, 0, 11);
    wait_clk(4);
    chk("e1_release_held", int'(held_cnt), 0);

    // backpressure: second event is dropped, table still updates
    evt_ready = 1'b0;
    d0 = drop_seen;
    push(9'h01D, 0, 0);
    send_frame(8'h1D, 0, 11);
    wait_clk(4);
    chk("bp_valid", int'(evt_valid), 1);
    chk("bp_code1", int'(evt_code), 9'h01D);
    send_frame(8'h1B, 0, 11);
    wait_clk(4);
    chk("bp_code2", int'(evt_code), 9'h01D);
    chk("bp_break", int'(evt_break), 0);
    chk("bp_drops", drop_seen - d0, 1);
    chk("bp_held", int'(held_cnt), 2);
    chk("bp_state", int'(key_state), 2);
    evt_ready = 1'b1;
    wait_clk(4);
    chk("bp_drained", int'(evt_valid), 0);
    chk("bp_sb_empty", sb.size(), 0);

    // reset in the middle of an E0 sequence and a frame
    e0 = err_seen;
    send_frame(8'hE0, 0, 11);
    send_frame(8'h72, 0, 4);
    rst_n = 1'b0;
    wait_clk(3);
    chk("mid_rst_valid", int'(evt_valid), 0);
    chk("mid_rst_held", int'(held_cnt), 0);
    chk("mid_rst_state", int'(key_state), 0);
    rst_n = 1'b1;
    wait_clk(TMO + 20);
    push(9'h072, 0, 0);
    send_frame(8'h72, 0, 11);
    wait_clk(4);
    chk("post_rst_held", int'(held_cnt), 1);
    chk("post_rst_state", int'(key_state), 3);
    chk("post_rst_err", err_seen - e0, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
